mux_pkt_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that drives the select of the 2:1 flit mux.
- Grants one input port at a head flit and holds that grant until the matching tail flit is accepted downstream, so packets never interleave.
- Sits beside the mux: sees the valid and flit-type fields of both inputs plus downstream ready; produces sel, per-port acks and status.

---
 rtl/mux_pkt_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mux_pkt_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkt_arbiter
//  Description : Packet-aware round-robin arbiter for a 2:1 flit mux.
//                A port is granted on a head flit and keeps the grant until
//                its tail flit is accepted downstream, so packets from the
//                two ports never interleave.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   rising-edge clock
//    rst_             in   asynchronous active-low reset
//    ivalid_0/1       in   per-port flit valid
//    itype_0/1        in   per-port flit type (NONE/HEAD/TAIL/DATA)
//    oready           in   downstream accepts the mux output this cycle
//    sel              out  mux select, one-hot in [1:0], upper bits zero
//    ack_0/1          out  per-port flit consumed this cycle
//    busy             out  a packet is in flight (locked state)
//    err              out  sticky protocol-error flag
// ----------------------------------------------------------------------------
//  Build option
//    ARB_TIMEOUT_EN   when defined, a lock with TIMEOUT consecutive cycles
//                     without an ack is forcibly released and err is set.
// ============================================================================
module mux_pkt_arbiter #(
    parameter int              PORTW   = 5,
    parameter int              TYPEW   = 2,
    parameter logic [TYPEW-1:0] T_NONE = 2'd0,
    parameter logic [TYPEW-1:0] T_HEAD = 2'd1,
    parameter logic [TYPEW-1:0] T_TAIL = 2'd2,
    parameter logic [TYPEW-1:0] T_DATA = 2'd3,
    parameter int              TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             oready,
    output logic [PORTW-1:0] sel,
    output logic             ack_0,
    output logic             ack_1,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;     // 0: port 0 wins a tie, 1: port 1 wins
    logic   err_q, err_d;

    logic   w_req_0, w_req_1;
    logic   w_gnt_0, w_gnt_1;
    logic   w_ack_0, w_ack_1;
    logic   w_stray_0, w_stray_1;

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
`endif

    assign w_req_0 = ivalid_0 && (itype_0 == T_HEAD);
    assign w_req_1 = ivalid_1 && (itype_1 == T_HEAD);

    // Body or tail flits arriving while no packet is open are orphans.
    assign w_stray_0 = ivalid_0 && ((itype_0 == T_DATA) || (itype_0 == T_TAIL));
    assign w_stray_1 = ivalid_1 && ((itype_1 == T_DATA) || (itype_1 == T_TAIL));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        w_gnt_0  = 1'b0;
        w_gnt_1  = 1'b0;
        w_ack_0  = 1'b0;
        w_ack_1  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Mealy grant: a head is steered through the mux in the
                // same cycle it arrives.
                w_gnt_0 = w_req_0 && (!w_req_1 || !rr_ptr_q);
                w_gnt_1 = w_req_1 && (!w_req_0 ||  rr_ptr_q);
                w_ack_0 = w_gnt_0 && ivalid_0 && oready;
                w_ack_1 = w_gnt_1 && ivalid_1 && oready;
                // The lock only starts once the head is actually accepted;
                // a stalled head keeps the grant because rr_ptr is untouched.
                if (w_ack_0) begin
                    state_d  = S_LOCK0;
                    rr_ptr_d = 1'b1;
                end else if (w_ack_1) begin
                    state_d  = S_LOCK1;
                    rr_ptr_d = 1'b0;
                end
                if (w_stray_0 || w_stray_1) begin
                    err_d = 1'b1;
                end
            end
            S_LOCK0: begin
                w_gnt_0 = 1'b1;
                w_ack_0 = ivalid_0 && oready;
                if (w_ack_0 && (itype_0 == T_TAIL)) begin
                    state_d = S_IDLE;
                end
                if (ivalid_0 && ((itype_0 == T_HEAD) || (itype_0 == T_NONE))) begin
                    err_d = 1'b1;
                end
            end
            S_LOCK1: begin
                w_gnt_1 = 1'b1;
                w_ack_1 = ivalid_1 && oready;
                if (w_ack_1 && (itype_1 == T_TAIL)) begin
                    state_d = S_IDLE;
                end
                if (ivalid_1 && ((itype_1 == T_HEAD) || (itype_1 == T_NONE))) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        // Watchdog on a stuck lock: counts consecutive ack-less cycles.
        if ((state_q == S_IDLE) || w_ack_0 || w_ack_1) begin
            cnt_d = '0;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign sel   = {{(PORTW-2){1'b0}}, w_gnt_1, w_gnt_0};
    assign ack_0 = w_ack_0;
    assign ack_1 = w_ack_1;
    assign busy  = (state_q != S_IDLE);
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_pkt_arbiter
//  Description : Directed self-checking bench for mux_pkt_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_pkt_arbiter;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] T = 2'd2;
    localparam logic [1:0] D = 2'd3;

    logic       clk;
    logic       rst_;
    logic       ivalid_0, ivalid_1, oready;
    logic [1:0] itype_0, itype_1;
    logic [4:0] sel;
    logic       ack_0, ack_1, busy, err;

    int n_checks = 0;
    int n_pass   = 0;

    mux_pkt_arbiter dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid_0 (ivalid_0),
        .itype_0  (itype_0),
        .ivalid_1 (ivalid_1),
        .itype_1  (itype_1),
        .oready   (oready),
        .sel      (sel),
        .ack_0    (ack_0),
        .ack_1    (ack_1),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs on the falling edge, settle, then return.
    task automatic drive(input logic v0, input logic [1:0] t0,
                         input logic v1, input logic [1:0] t1, input logic r);
        @(negedge clk);
        ivalid_0 = v0; itype_0 = t0;
        ivalid_1 = v1; itype_1 = t1;
        oready   = r;
        #1;
    endtask

    task automatic expo(input string tag, input logic [4:0] e_sel,
                        input logic e_a0, input logic e_a1, input logic e_busy);
        chk($sformatf("%s.sel", tag),  32'(sel),   32'(e_sel));
        chk($sformatf("%s.ack0", tag), 32'(ack_0), 32'(e_a0));
        chk($sformatf("%s.ack1", tag), 32'(ack_1), 32'(e_a1));
        chk($sformatf("%s.busy", tag), 32'(busy),  32'(e_busy));
    endtask

    initial begin
        int ack1_cnt;
        int busy_cnt;

        rst_ = 1'b0;
        ivalid_0 = 1'b0; itype_0 = N;
        ivalid_1 = 1'b0; itype_1 = N;
        oready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expo("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("reset.err", 32'(err), 32'd0);
        rst_ = 1'b1;

        // Port 1 alone: head + 20 data + tail.
        ack1_cnt = 0;
        busy_cnt = 0;
        drive(0, N, 1, H, 1);
        expo("p1_head", 5'b00010, 1'b0, 1'b1, 1'b0);
        ack1_cnt += int'(ack_1); busy_cnt += int'(busy);
        for (int i = 0; i < 20; i++) begin
            drive(0, N, 1, D, 1);
            chk("p1_data.sel", 32'(sel), 32'd2);
            ack1_cnt += int'(ack_1); busy_cnt += int'(busy);
        end
        drive(0, N, 1, T, 1);
        expo("p1_tail", 5'b00010, 1'b0, 1'b1, 1'b1);
        ack1_cnt += int'(ack_1); busy_cnt += int'(busy);
        chk("p1_ack_cycles", 32'(ack1_cnt), 32'd22);
        chk("p1_busy_cycles", 32'(busy_cnt), 32'd21);
        drive(0, N, 0, N, 1);
        expo("p1_idle", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("p1_idle.err", 32'(err), 32'd0);

        // Both heads: rr_ptr is back at 0, so port 0 wins; port 1 waits.
        drive(1, H, 1, H, 1);
        expo("both1_head", 5'b00001, 1'b1, 1'b0, 1'b0);
        drive(1, D, 1, H, 1);
        expo("p0_locked_p1_req", 5'b00001, 1'b1, 1'b0, 1'b1);
        drive(1, T, 1, H, 1);
        expo("p0_tail_p1_req", 5'b00001, 1'b1, 1'b0, 1'b1);
        // Port 1 granted right after the tail, no bubble.
        drive(0, N, 1, H, 1);
        expo("p1_no_bubble", 5'b00010, 1'b0, 1'b1, 1'b0);
        drive(0, N, 1, T, 1);
        expo("p1_short_tail", 5'b00010, 1'b0, 1'b1, 1'b1);
        // Both heads again: port 1 was served last, port 0 wins.
        drive(1, H, 1, H, 1);
        expo("both2_head", 5'b00001, 1'b1, 1'b0, 1'b0);

        // Downstream stall inside the packet.
        for (int i = 0; i < 3; i++) begin
            drive(1, D, 0, N, 0);
            expo("stall", 5'b00001, 1'b0, 1'b0, 1'b1);
        end
        drive(1, D, 0, N, 1);
        expo("stall_resume", 5'b00001, 1'b1, 1'b0, 1'b1);
        drive(0, N, 0, N, 1);
        expo("bubble", 5'b00001, 1'b0, 1'b0, 1'b1);
        // Tail closes the lock; port 1 head on the same edge is not taken.
        drive(1, T, 1, H, 1);
        expo("tail_vs_head", 5'b00001, 1'b1, 1'b0, 1'b1);

        // Head granted while downstream is not ready: held, not acked.
        drive(0, N, 1, H, 0);
        expo("head_stall", 5'b00010, 1'b0, 1'b0, 1'b0);
        drive(0, N, 1, H, 1);
        expo("head_accept", 5'b00010, 1'b0, 1'b1, 1'b0);
        drive(1, H, 1, T, 1);
        expo("p1_tail_p0_head", 5'b00010, 1'b0, 1'b1, 1'b1);
        drive(1, H, 0, N, 1);
        expo("p0_after_p1", 5'b00001, 1'b1, 1'b0, 1'b0);
        drive(1, T, 0, N, 1);
        expo("p0_tail2", 5'b00001, 1'b1, 1'b0, 1'b1);
        drive(0, N, 0, N, 1);
        expo("idle2", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("idle2.err", 32'(err), 32'd0);

        // Orphan data flit while idle: sticky error.
        drive(1, D, 0, N, 1);
        expo("orphan", 5'b00000, 1'b0, 1'b0, 1'b0);
        drive(0, N, 0, N, 1);
        chk("orphan.err", 32'(err), 32'd1);
        drive(0, N, 0, N, 1);
        chk("orphan.err_sticky", 32'(err), 32'd1);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("err_cleared", 32'(err), 32'd0);
        rst_ = 1'b1;

        // Head inside a locked packet flags an error but keeps the lock.
        drive(0, N, 1, H, 1);
        expo("p1_lock", 5'b00010, 1'b0, 1'b1, 1'b0);
        drive(0, N, 1, H, 1);
        expo("dup_head", 5'b00010, 1'b0, 1'b1, 1'b1);
        drive(0, N, 1, D, 1);
        chk("dup_head.err", 32'(err), 32'd1);
        chk("dup_head.busy", 32'(busy), 32'd1);

        // Reset mid-packet drops the lock immediately.
        #2;
        rst_ = 1'b0;
        #1;
        expo("mid_reset", 5'b00000, 1'b0, 1'b0, 1'b0);
        chk("mid_reset.err", 32'(err), 32'd0);
        rst_ = 1'b1;
        drive(0, N, 0, N, 1);
        expo("post_reset", 5'b00000, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
